result_writeback_ctrl: RTL and testbench

- Sits directly downstream of the systolic array, replacing the ad-hoc result deskew, reverse and write-enable path in front of the result SRAM.
- Takes the column-skewed partial-sum outputs (lane i arrives i cycles after lane 0) and realigns them into one row word.
- Optionally reverses lane order, then writes each row to the result SRAM at consecutive addresses from a programmed base.
- Reports busy/done and a sticky error for unexpected valids.

---
 rtl/result_writeback_ctrl.sv | 111 +++++++++++
 tb/tb_result_writeback_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_ctrl.sv
// result_writeback_ctrl: deskews systolic-array column outputs into row words and
// writes them to the result SRAM at consecutive addresses, with busy/done/err status.
module result_writeback_ctrl #(
    parameter int MATRIX_SIZE    = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int ADDRESSSIZE    = 10,
    parameter bit REVERSE        = 1
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    start,
    input  logic [ADDRESSSIZE-1:0]                  base_addr,
    input  logic [ADDRESSSIZE:0]                    num_rows,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]   result,
    input  logic                                    result_valid,
    output logic                                    wr_en,
    output logic [ADDRESSSIZE-1:0]                  wr_addr,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]   wr_data,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err
);
    localparam int N  = MATRIX_SIZE;
    localparam int BW = PARTIAL_SUM_BW;
    localparam int AW = ADDRESSSIZE;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          r_state, w_next;
    logic [AW-1:0]   r_base;
    logic [AW:0]     r_rows, r_acnt, r_wcnt;
    logic [N-2:0]    r_vld;
    logic [N*BW-1:0] w_row;
    logic            w_start, w_acc, w_wr;

    assign w_start = (r_state == IDLE) && start;
    assign w_acc   = (r_state == RUN) && result_valid;
    assign w_wr    = r_vld[N-2];
    assign busy    = (r_state == RUN) || (r_state == DRAIN);
    assign done    = (r_state == DONE);

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (num_rows == '0) ? DONE : RUN;
            RUN:     if (w_acc && (r_acnt + 1'b1) == r_rows) w_next = DRAIN;
            DRAIN:   if (r_wcnt == r_rows) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // The start clear takes priority over an err set in the same cycle.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_base <= '0;
            r_rows <= '0;
            r_acnt <= '0;
            r_wcnt <= '0;
            err    <= 1'b0;
        end else begin
            if (w_start) begin
                r_base <= base_addr;
                r_rows <= num_rows;
                r_acnt <= '0;
                r_wcnt <= '0;
            end else begin
                if (w_acc) r_acnt <= r_acnt + 1'b1;
                if (w_wr)  r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_start)                                err <= 1'b0;
            else if (result_valid && r_state != RUN)    err <= 1'b1;
        end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_vld   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            r_vld   <= {r_vld[N-3:0], w_acc};
            wr_en   <= w_wr;
            wr_addr <= w_wr ? r_base + r_wcnt[AW-1:0] : '0;
            wr_data <= w_wr ? w_row : '0;
        end

    // Lane g arrives g cycles late, so it gets g fewer stages; the output register is the last stage.
    for (genvar g = 0; g < N; g++) begin : g_lane
        localparam int D = N - 1 - g;
        localparam int S = REVERSE ? N - 1 - g : g;
        logic [BW-1:0] w_in;
        assign w_in = result[g*BW +: BW];
        if (D == 0) begin : g_direct
            assign w_row[S*BW +: BW] = w_in;
        end else begin : g_dly
            logic [BW-1:0] r_sr [D];
            always_ff @(posedge clk or negedge rstn)
                if (!rstn) begin
                    for (int k = 0; k < D; k++) r_sr[k] <= '0;
                end else begin
                    r_sr[0] <= w_in;
                    for (int k = 1; k < D; k++) r_sr[k] <= r_sr[k-1];
                end
            assign w_row[S*BW +: BW] = r_sr[D-1];
        end
    end
endmodule

// File: tb/tb_result_writeback_ctrl.sv
// tb_result_writeback_ctrl: scoreboard bench driving REVERSE=1 and REVERSE=0 instances
// with identical skewed stimulus; a negedge monitor checks every write against the queues.
module tb_result_writeback_ctrl;
    localparam int N  = 8;
    localparam int BW = 20;
    localparam int AW = 10;
    localparam int W  = N * BW;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [W-1:0]  lanes;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_rows = '0;
    logic [W-1:0]  result = '0;
    logic          result_valid = 1'b0;

    logic          wr_en1, busy1, done1, err1, wr_en0, busy0, done0, err0;
    logic [AW-1:0] wr_addr1, wr_addr0;
    logic [W-1:0]  wr_data1, wr_data0;

    exp_t          q1[$], q0[$];
    logic [W-1:0]  hist [N];
    int            tests = 0, fails = 0, cyc = 0;

    always #5 clk = ~clk;

    result_writeback_ctrl #(.REVERSE(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .result(result), .result_valid(result_valid), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .busy(busy1), .done(done1), .err(err1)
    );

    result_writeback_ctrl #(.REVERSE(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .result(result), .result_valid(result_valid), .wr_en(wr_en0), .wr_addr(wr_addr0),
        .wr_data(wr_data0), .busy(busy0), .done(done0), .err(err0)
    );

    function automatic logic [W-1:0] mk(input int v0);
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[i*BW +: BW] = BW'(v0 + i);
        return r;
    endfunction

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[(N-1-i)*BW +: BW] = x[i*BW +: BW];
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic mon(input int id, input logic en, input logic [AW-1:0] a, input logic [W-1:0] d);
        exp_t e;
        if (!en) begin
            check(id ? "idle_data1" : "idle_data0", d, '0);
            return;
        end
        if ((id == 1 && q1.size() == 0) || (id == 0 && q0.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write dut%0d: got write to addr %0d, required none (cycle %0d)", id, a, cyc);
            return;
        end
        if (id == 1) e = q1.pop_front();
        else         e = q0.pop_front();
        check("wr_cycle", W'(cyc), W'(e.cyc));
        check("wr_addr", W'(a), W'(e.addr));
        check(id ? "wr_data_rev" : "wr_data_fwd", d, id ? rev(e.lanes) : e.lanes);
    endtask

    always @(negedge clk)
        if (rstn) begin
            mon(1, wr_en1, wr_addr1, wr_data1);
            mon(0, wr_en0, wr_addr0, wr_data0);
        end

    // Presents lane i of the row issued i cycles ago, mimicking the array's column skew.
    task automatic tick(input logic v, input logic [W-1:0] row, input logic s);
        start = s;
        result_valid = v;
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = row;
        for (int i = 0; i < N; i++) result[i*BW +: BW] = hist[i][i*BW +: BW];
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        result_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, '0, 1'b0);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [W-1:0] row);
        exp_t e;
        e = '{cyc + N, a, row};
        q1.push_back(e);
        q0.push_back(e);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int n);
        base_addr = b;
        num_rows = (AW+1)'(n);
        tick(1'b0, '0, 1'b1);
    endtask

    task automatic run_rows(input logic [AW-1:0] b, input int n, input int v0, output int tl);
        tl = cyc;
        for (int r = 0; r < n; r++) begin
            tl = cyc;
            push(AW'(b + AW'(r)), mk(v0 + 16 * r));
            tick(1'b1, mk(v0 + 16 * r), 1'b0);
        end
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        for (int k = 0; k < 40 && !done1; k++) idle(1);
        check(name, W'(cyc), W'(exp_cyc));
        check("done_both", W'(done0), W'(1));
        check("busy_at_done", W'(busy1), W'(0));
        idle(1);
        check("done_pulse", W'(done1), W'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int tl, s, nd;
        for (int k = 0; k < N; k++) hist[k] = '0;
        #1 rstn = 1'b0;
        #1;
        check("rst_wr_en", W'(wr_en1), W'(0));
        check("rst_busy", W'(busy1), W'(0));
        check("rst_done", W'(done1), W'(0));
        check("rst_err", W'(err1), W'(0));
        check("rst_data", wr_data1, '0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        idle(2);

        do_start(5, 1);
        check("busy_run", W'(busy1), W'(1));
        run_rows(5, 1, 100, tl);
        wait_done(tl + N + 1, "done_single");

        do_start(0, 4);
        run_rows(0, 4, 200, tl);
        wait_done(tl + N + 1, "done_stream");
        check("err_stream", W'(err1), W'(0));

        do_start(1022, 3);
        run_rows(1022, 3, 300, tl);
        wait_done(tl + N + 1, "done_wrap");

        s = cyc;
        do_start(0, 0);
        wait_done(s + 1, "done_zero");

        do_start(10, 3);
        push(10, mk(400));
        tick(1'b1, mk(400), 1'b0);
        base_addr = 500;
        num_rows = 1;
        push(11, mk(416));
        tick(1'b1, mk(416), 1'b1);
        tl = cyc;
        push(12, mk(432));
        tick(1'b1, mk(432), 1'b0);
        wait_done(tl + N + 1, "done_ignored_start");
        check("err_ignored_start", W'(err1), W'(0));

        tick(1'b1, mk(900), 1'b0);
        check("err_idle_valid", W'(err1), W'(1));
        idle(N + 2);
        check("err_sticky", W'(err0), W'(1));
        do_start(20, 4);
        check("err_cleared", W'(err1), W'(0));
        run_rows(20, 4, 500, tl);
        tick(1'b1, mk(999), 1'b0);
        check("err_extra_valid", W'(err1), W'(1));
        wait_done(tl + N + 1, "done_extra");
        base_addr = 40;
        num_rows = 1;
        tick(1'b1, mk(50), 1'b1);
        check("err_start_priority", W'(err1), W'(0));
        run_rows(40, 1, 600, tl);
        wait_done(tl + N + 1, "done_start_valid");

        do_start(60, 4);
        push(60, mk(700));
        tick(1'b1, mk(700), 1'b0);
        push(61, mk(716));
        tick(1'b1, mk(716), 1'b0);
        tick(1'b1, mk(732), 1'b0);
        tick(1'b1, mk(748), 1'b0);
        idle(5);
        #5 rstn = 1'b0;
        #1;
        check("rst_mid_wr_en", W'(wr_en1), W'(0));
        check("rst_mid_addr", W'(wr_addr1), W'(0));
        check("rst_mid_data", wr_data1, '0);
        check("rst_mid_busy", W'(busy1), W'(0));
        @(posedge clk);
        #1;
        cyc++;
        rstn = 1'b1;
        nd = 0;
        for (int k = 0; k < 2 * N; k++) begin
            idle(1);
            if (done1 || done0) nd++;
        end
        check("rst_no_done", W'(nd), W'(0));
        do_start(100, 2);
        run_rows(100, 2, 800, tl);
        wait_done(tl + N + 1, "done_after_reset");

        idle(2);
        check("q1_empty", W'(q1.size()), W'(0));
        check("q0_empty", W'(q0.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
